// File: rtl/adder_bist_pkg.sv
// Shared types and sizing helpers for the adder BIST engine.
// Vector width and count are derived from the operand width of the adder under test.
package adder_bist_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int DEFAULT_NUM_INPUT_BITS = 4;
    localparam int VEC_BITS = 2 * DEFAULT_NUM_INPUT_BITS + 1;
    localparam int NUM_VECS = 2 ** VEC_BITS;

    // {carry_in, b, a} width for an N-bit adder
    function automatic int vec_bits_of(input int n);
        return 2 * n + 1;
    endfunction

endpackage

// File: rtl/bist_settle_timer.sv
// Down-counter that times the settle window of each applied vector.
// Load sets CYCLES-1; expired is high while the count sits at zero.
module bist_settle_timer #(
    parameter int CYCLES = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic expired
);

    localparam int W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [W-1:0] LOAD_VAL = W'(CYCLES - 1);
    localparam logic [W-1:0] CNT_ONE  = W'(1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= LOAD_VAL;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - CNT_ONE;
        end
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/adder_bist_ctrl.sv
// Exhaustive on-chip self-test of an N-bit combinational adder: walks every {carry_in,b,a},
// holds each vector for SETTLE_CYCLES, then compares against a golden sum and tallies mismatches.
module adder_bist_ctrl
    import adder_bist_pkg::*;
#(
    parameter int NUM_INPUT_BITS = 4,
    parameter int SETTLE_CYCLES  = 10,
    parameter int ERR_CNT_BITS   = 16
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    output logic [NUM_INPUT_BITS-1:0]           dut_a,
    output logic [NUM_INPUT_BITS-1:0]           dut_b,
    output logic                                dut_carry_in,
    input  logic [NUM_INPUT_BITS-1:0]           dut_sum,
    input  logic                                dut_carry_out,
    output logic                                busy,
    output logic                                done,
    output logic                                pass,
    output logic [ERR_CNT_BITS-1:0]             err_count,
    output logic [2*NUM_INPUT_BITS:0]           first_fail_vec,
    output logic                                first_fail_vld
);

    localparam int N  = NUM_INPUT_BITS;
    localparam int VB = vec_bits_of(NUM_INPUT_BITS);
    localparam logic [VB-1:0]           VEC_ONE = VB'(1);
    localparam logic [ERR_CNT_BITS-1:0] ERR_ONE = ERR_CNT_BITS'(1);

    state_t         state;
    state_t         next_state;
    logic [VB-1:0]  vec;
    logic           start_ok;
    logic           timer_load;
    logic           expired;
    logic           last_vec;
    logic [N:0]     golden;
    logic           mismatch;
    logic           busy_nxt;
    logic           done_nxt;
    logic           pass_nxt;

    assign start_ok   = start && ((state == IDLE) || (state == DONE));
    assign last_vec   = (vec == '1);
    assign timer_load = (next_state == APPLY) && (state != APPLY);

    bist_settle_timer #(
        .CYCLES (SETTLE_CYCLES)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (timer_load),
        .en      (state == APPLY),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start)    next_state = APPLY;
            APPLY:   if (expired)  next_state = CHECK;
            CHECK:   next_state = last_vec ? DONE : APPLY;
            DONE:    if (start)    next_state = APPLY;
            default: next_state = IDLE;
        endcase
    end

    // Status flags are registered from the current state, so they trail the state by one edge;
    // a start taken in DONE clears done/pass on that same edge.
    always_comb begin
        busy_nxt = (state == APPLY) || (state == CHECK);
        done_nxt = (state == DONE) && !start;
        pass_nxt = done_nxt && (err_count == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
            pass <= 1'b0;
        end else begin
            busy <= busy_nxt;
            done <= done_nxt;
            pass <= pass_nxt;
        end
    end

    assign golden   = {1'b0, vec[N-1:0]} + {1'b0, vec[2*N-1:N]} + {{N{1'b0}}, vec[2*N]};
    assign mismatch = ({dut_carry_out, dut_sum} != golden);

    always_ff @(posedge clk) begin
        if (rst) begin
            vec            <= '0;
            err_count      <= '0;
            first_fail_vec <= '0;
            first_fail_vld <= 1'b0;
        end else if (start_ok) begin
            vec            <= '0;
            err_count      <= '0;
            first_fail_vec <= '0;
            first_fail_vld <= 1'b0;
        end else if (state == CHECK) begin
            if (mismatch) begin
                if (err_count != '1) begin
                    err_count <= err_count + ERR_ONE;
                end
                if (!first_fail_vld) begin
                    first_fail_vec <= vec;
                    first_fail_vld <= 1'b1;
                end
            end
            if (!last_vec) begin
                vec <= vec + VEC_ONE;
            end
        end
    end

    assign dut_a        = vec[N-1:0];
    assign dut_b        = vec[2*N-1:N];
    assign dut_carry_in = vec[2*N];

endmodule

// File: tb/tb_adder_bist_ctrl.sv
// Directed bench: two BIST instances (16-bit and 4-bit error counters) each test a modelled
// adder that can be golden, sum[0] stuck-at-0, or carry_out stuck-at-1.
module tb_adder_bist_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    int   fault_mode = 0;

    logic [3:0] a0, b0, s0, a1, b1, s1;
    logic       ci0, co0, ci1, co1;
    logic       busy0, done0, pass0, ffv0, busy1, done1, pass1, ffv1;
    logic [15:0] err0;
    logic [3:0]  err1;
    logic [8:0]  ffvec0, ffvec1;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    function automatic logic [4:0] adder_model(input logic [3:0] a, input logic [3:0] b,
                                               input logic c, input int mode);
        logic [4:0] r;
        r = {1'b0, a} + {1'b0, b} + {4'b0, c};
        if (mode == 1) r[0] = 1'b0;
        if (mode == 2) r[4] = 1'b1;
        return r;
    endfunction

    always_comb {co0, s0} = adder_model(a0, b0, ci0, fault_mode);
    always_comb {co1, s1} = adder_model(a1, b1, ci1, fault_mode);

    adder_bist_ctrl #(.NUM_INPUT_BITS(4), .SETTLE_CYCLES(10), .ERR_CNT_BITS(16)) dut (
        .clk(clk), .rst(rst), .start(start),
        .dut_a(a0), .dut_b(b0), .dut_carry_in(ci0),
        .dut_sum(s0), .dut_carry_out(co0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
        .first_fail_vec(ffvec0), .first_fail_vld(ffv0)
    );

    adder_bist_ctrl #(.NUM_INPUT_BITS(4), .SETTLE_CYCLES(10), .ERR_CNT_BITS(4)) dut_sat (
        .clk(clk), .rst(rst), .start(start),
        .dut_a(a1), .dut_b(b1), .dut_carry_in(ci1),
        .dut_sum(s1), .dut_carry_out(co1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .first_fail_vec(ffvec1), .first_fail_vld(ffv1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Pulses start, then counts edges until done and the number of cycles busy was high.
    // A second start pulse is optionally issued mid-run to confirm it is ignored.
    task automatic run(input int restart_at, output int cycles, output int busy_cycles);
        start = 1'b1;
        cyc();
        start = 1'b0;
        check("done_cleared_on_start", 32'(done0), 32'd0);
        check("pass_cleared_on_start", 32'(pass0), 32'd0);
        cycles = 0;
        busy_cycles = 0;
        while (!done0 && cycles < 6000) begin
            start = (restart_at > 0 && cycles == restart_at) ? 1'b1 : 1'b0;
            cyc();
            cycles++;
            if (busy0) busy_cycles++;
        end
        start = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, 32'(busy0), 32'd0);
        check({tag, "_done"}, 32'(done0), 32'd0);
        check({tag, "_pass"}, 32'(pass0), 32'd0);
        check({tag, "_err"},  32'(err0),  32'd0);
        check({tag, "_ffv"},  32'(ffv0),  32'd0);
        check({tag, "_ffvec"}, 32'(ffvec0), 32'd0);
        check({tag, "_dut_vec"}, 32'({ci0, b0, a0}), 32'd0);
        check({tag, "_sat_busy"}, 32'(busy1), 32'd0);
    endtask

    task automatic check_golden_run(input string tag, input int cycles, input int busy_cycles);
        check({tag, "_done_cycle"}, 32'(cycles), 32'd5633);
        check({tag, "_busy_cycles"}, 32'(busy_cycles), 32'd5632);
        check({tag, "_done"}, 32'(done0), 32'd1);
        check({tag, "_busy_at_done"}, 32'(busy0), 32'd0);
        check({tag, "_pass"}, 32'(pass0), 32'd1);
        check({tag, "_err"}, 32'(err0), 32'd0);
        check({tag, "_ffv"}, 32'(ffv0), 32'd0);
        check({tag, "_last_vec"}, 32'({ci0, b0, a0}), 32'h1ff);
        check({tag, "_sat_pass"}, 32'(pass1), 32'd1);
    endtask

    initial begin
        int cyc_n;
        int busy_n;

        rst = 1'b1;
        cyc();
        cyc();
        check_reset_outputs("reset");
        rst = 1'b0;
        cyc();

        // Golden adder
        fault_mode = 0;
        run(0, cyc_n, busy_n);
        check_golden_run("golden", cyc_n, busy_n);

        // sum[0] stuck-at-0: every odd total mismatches
        fault_mode = 1;
        run(0, cyc_n, busy_n);
        check("s0_done_cycle", 32'(cyc_n), 32'd5633);
        check("s0_pass", 32'(pass0), 32'd0);
        check("s0_err", 32'(err0), 32'd256);
        check("s0_ffv", 32'(ffv0), 32'd1);
        check("s0_ffvec", 32'(ffvec0), 32'h001);
        check("s0_sat_err", 32'(err1), 32'd15);
        check("s0_sat_ffvec", 32'(ffvec1), 32'h001);
        check("s0_sat_pass", 32'(pass1), 32'd0);

        // carry_out stuck-at-1: every total below 16 mismatches (136 + 120)
        fault_mode = 2;
        run(0, cyc_n, busy_n);
        check("co1_err", 32'(err0), 32'd256);
        check("co1_ffv", 32'(ffv0), 32'd1);
        check("co1_ffvec", 32'(ffvec0), 32'h000);
        check("co1_pass", 32'(pass0), 32'd0);
        check("co1_sat_err", 32'(err1), 32'd15);

        // Reset 100 cycles into a run aborts without partial result
        fault_mode = 1;
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int i = 0; i < 100; i++) cyc();
        check("midrun_busy", 32'(busy0), 32'd1);
        rst = 1'b1;
        cyc();
        check_reset_outputs("abort");
        rst = 1'b0;
        fault_mode = 0;
        cyc();
        run(0, cyc_n, busy_n);
        check_golden_run("after_abort", cyc_n, busy_n);

        // start during busy is ignored, then restart from DONE
        run(50, cyc_n, busy_n);
        check_golden_run("ignored_start", cyc_n, busy_n);
        run(0, cyc_n, busy_n);
        check_golden_run("restart_from_done", cyc_n, busy_n);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
